// File: rtl/gt_seq_cmp.sv
// ---------------------------------------------------------------------------
// gt_seq_cmp -- multi-cycle magnitude comparator
//
// Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and stops
// on the first slice that differs. Latency is 1..WIDTH/DIGIT cycles after the
// accepted start edge; done pulses for one cycle when gt/eq/lt become valid.
// Results hold until the next accepted start, which clears them.
//
// Parameters:
//   WIDTH  operand width (multiple of DIGIT)
//   DIGIT  bits compared per cycle (1..WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, sampled only while idle
//   signed_mode  (SIGNED_CMP_EN only) two's-complement compare when 1
//   a, b         operands, captured on the accepted start edge
//   busy         high while the compare is running
//   done         one-cycle result-valid pulse
//   gt, eq, lt   a > b, a == b, a < b (one-hot after done)
//
// Optional feature macro: SIGNED_CMP_EN
// ---------------------------------------------------------------------------
module gt_seq_cmp #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SIGNED_CMP_EN
  input  logic             signed_mode,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic [WIDTH-1:0] w_a_load;
  logic [WIDTH-1:0] w_b_load;
  logic [DIGIT-1:0] w_a_sl;
  logic [DIGIT-1:0] w_b_sl;

  // Operand values as loaded. In signed mode the sign bits are flipped
  // (offset binary) so the unsigned slice compare orders two's-complement
  // values correctly without any extra logic in the scan path.
  always_comb begin
    w_a_load = a;
    w_b_load = b;
`ifdef SIGNED_CMP_EN
    w_a_load[WIDTH-1] = a[WIDTH-1] ^ signed_mode;
    w_b_load[WIDTH-1] = b[WIDTH-1] ^ signed_mode;
`endif
  end

  assign w_a_sl = r_a[WIDTH-1 -: DIGIT];
  assign w_b_sl = r_b[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= w_a_load;
            r_b     <= w_b_load;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_a_sl != w_b_sl) begin
            r_gt    <= (w_a_sl > w_b_sl);
            r_lt    <= (w_a_sl < w_b_sl);
            r_eq    <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else if (r_cnt == LAST_CNT) begin
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            // Next slice moves into the top DIGIT bits.
            r_a   <= r_a << DIGIT;
            r_b   <= r_b << DIGIT;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule

// File: tb/tb_gt_seq_cmp.sv
module tb_gt_seq_cmp;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy, done, gt, eq, lt;
  logic       signed_mode;

  logic       s_start;
  logic [1:0] s_a;
  logic [1:0] s_b;
  logic       s_busy, s_done, s_gt, s_eq, s_lt;

  int checks = 0;
  int errors = 0;

  gt_seq_cmp #(.WIDTH(8), .DIGIT(2)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef SIGNED_CMP_EN
    .signed_mode(signed_mode),
`endif
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .gt         (gt),
    .eq         (eq),
    .lt         (lt)
  );

  gt_seq_cmp #(.WIDTH(2), .DIGIT(2)) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
`ifdef SIGNED_CMP_EN
    .signed_mode(1'b0),
`endif
    .a          (s_a),
    .b          (s_b),
    .busy       (s_busy),
    .done       (s_done),
    .gt         (s_gt),
    .eq         (s_eq),
    .lt         (s_lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a compare, scramble inputs after the start edge, then wait for done
  // and check latency, result and the one-cycle done pulse.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic sm, input int exp_n,
                         input logic egt, input logic eeq, input logic elt);
    int k;
    signed_mode = sm;
    a = va; b = vb; start = 1'b1;
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    check({tag, "_busy0"}, busy, 1'b1);
    check({tag, "_clr"}, {gt, eq, lt}, 3'b000);
    k = 0;
    while (k < 12) begin
      step();
      k++;
      if (done) break;
    end
    check({tag, "_lat"}, k, exp_n);
    check({tag, "_res"}, {gt, eq, lt}, {egt, eeq, elt});
    check({tag, "_busyd"}, busy, 1'b0);
    step();
    check({tag, "_pulse"}, done, 1'b0);
    check({tag, "_hold"}, {gt, eq, lt}, {egt, eeq, elt});
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0;
    #12;
    check("rst_outs", {busy, done, gt, eq, lt}, 5'b00000);
    check("rst_small", {s_busy, s_done, s_gt, s_eq, s_lt}, 5'b00000);
    rst_n = 1'b1;
    step();

    // Early exit on the top slice
    run_cmp("early", 8'hC3, 8'h43, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    // Full-latency equality and last-slice difference
    run_cmp("equal", 8'h5A, 8'h5A, 1'b0, 4, 1'b0, 1'b1, 1'b0);
    run_cmp("lastlt", 8'h50, 8'h51, 1'b0, 4, 1'b0, 1'b0, 1'b1);
    run_cmp("midgt", 8'h38, 8'h34, 1'b0, 3, 1'b1, 1'b0, 1'b0);

    // start while busy is ignored
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    step();
    a = 8'h00; b = 8'hFF;               // start still high: must be ignored
    step();
    step();
    start = 1'b0;
    step();
    step();
    check("ign_done", done, 1'b1);
    check("ign_res", {gt, eq, lt}, 3'b010);
    step();
    check("ign_noq", {busy, done}, 2'b00);

    // Back-to-back: start during the done cycle
    a = 8'hC3; b = 8'h43; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("b2b_done1", {done, gt}, 2'b11);
    a = 8'h01; b = 8'h02; start = 1'b1;
    step();
    start = 1'b0;
    check("b2b_busy", busy, 1'b1);
    check("b2b_clr", {done, gt, eq, lt}, 4'b0000);
    k = 0;
    while (k < 12) begin
      step();
      k++;
      if (done) break;
    end
    check("b2b_lat", k, 4);
    check("b2b_res", {gt, eq, lt}, 3'b001);
    step();

    // Reset mid-compare
    a = 8'h01; b = 8'h02; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rmid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rmid_async", {busy, done, gt, eq, lt}, 5'b00000);
    step();
    step();
    check("rmid_nodone", {busy, done, gt, eq, lt}, 5'b00000);
    rst_n = 1'b1;
    step();
    check("rmid_idle", {busy, done}, 2'b00);
    run_cmp("after_rst", 8'h43, 8'hC3, 1'b0, 1, 1'b0, 1'b0, 1'b1);

`ifdef SIGNED_CMP_EN
    run_cmp("sgn1", 8'h80, 8'h01, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    run_cmp("sgn0", 8'h80, 8'h01, 1'b0, 1, 1'b1, 1'b0, 1'b0);
    run_cmp("sgn_eq", 8'hF0, 8'hF0, 1'b1, 4, 1'b0, 1'b1, 1'b0);
`endif

    // Exhaustive WIDTH=2 DIGIT=2: fixed one-cycle compare
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s_a = 2'(i); s_b = 2'(j); s_start = 1'b1;
        step();
        s_start = 1'b0;
        s_a = 2'($urandom); s_b = 2'($urandom);
        check($sformatf("sm_busy_%0d_%0d", i, j), s_busy, 1'b1);
        step();
        check($sformatf("sm_done_%0d_%0d", i, j), s_done, 1'b1);
        check($sformatf("sm_res_%0d_%0d", i, j), {s_gt, s_eq, s_lt},
              {(i > j) ? 1'b1 : 1'b0, (i == j) ? 1'b1 : 1'b0, (i < j) ? 1'b1 : 1'b0});
      end
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
